// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle: BCD digits and display controls in, anode/segment pins out.
interface sevenseg_scan_driver_if;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       lzb_en;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output sec_ones, sec_tens, min_ones, min_tens, lzb_en, blank,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  sec_ones, sec_tens, min_ones, min_tens, lzb_en, blank,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for an MM.SS stopwatch.
// Digits are snapshotted once per frame so a scanned frame never mixes values.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  sevenseg_scan_driver_if.slave  disp
);

  typedef enum logic [1:0] {
    SLOT_SEC_ONES = 2'd0,
    SLOT_SEC_TENS = 2'd1,
    SLOT_MIN_ONES = 2'd2,
    SLOT_MIN_TENS = 2'd3
  } slot_e;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NDIGITS = 4;

  slot_e                           idx, idx_nxt;
  logic [CNT_W-1:0]                div_cnt, div_nxt;
  logic [NDIGITS-1:0][DIGIT_W-1:0] snap, snap_nxt;
  logic [3:0]                      an_q, an_nxt;
  logic [6:0]                      seg_q, seg_nxt;
  logic                            dp_q, dp_nxt;
  logic                            ft_q, ft_nxt;
  logic                            tc;
  logic                            load;
  logic                            slot_dark;
  logic [DIGIT_W-1:0]              digit;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [DIGIT_W-1:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    tc        = (div_cnt == CNT_W'(REFRESH_DIV - 1));
    load      = tc && (idx == SLOT_MIN_TENS);
    div_nxt   = tc ? '0 : div_cnt + CNT_W'(1);
    idx_nxt   = idx;
    snap_nxt  = snap;
    if (tc) begin
      idx_nxt = slot_e'(idx + 2'd1);
    end
    if (load) begin
      snap_nxt = {disp.min_tens, disp.min_ones, disp.sec_tens, disp.sec_ones};
    end

    digit     = snap[idx];
    slot_dark = disp.blank || (disp.lzb_en && (idx == SLOT_MIN_TENS) && (digit == 4'd0));
    an_nxt    = slot_dark ? 4'hF : ~(4'b0001 << idx);
    seg_nxt   = slot_dark ? 7'h7F : bcd_to_seg(digit);
    dp_nxt    = !((idx == SLOT_MIN_ONES) && !disp.blank);
    ft_nxt    = load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= SLOT_SEC_ONES;
      snap    <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      idx     <= idx_nxt;
      snap    <= snap_nxt;
      an_q    <= an_nxt;
      seg_q   <= seg_nxt;
      dp_q    <= dp_nxt;
      ft_q    <= ft_nxt;
    end
  end

  assign disp.an         = an_q;
  assign disp.seg        = seg_q;
  assign disp.dp         = dp_q;
  assign disp.frame_tick = ft_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: directed scenarios then random digit/blank/reset
// traffic, checked every cycle against a frame-arithmetic reference model.
module tb_sevenseg_scan_driver;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sevenseg_scan_driver_if dif ();

  sevenseg_scan_driver #(.REFRESH_DIV(D), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (dif)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  // Reference: n counts clock edges since reset release; slot = (n / D) mod 4
  int         n_edges = 0;
  int         snap_m [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic       exp_ft;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, want);
    end
  endtask

  task automatic model_edge();
    int  cur;
    int  dig;
    bit  dark;
    if (rst) begin
      n_edges = 0;
      foreach (snap_m[i]) snap_m[i] = 0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      exp_ft  = 1'b0;
    end else begin
      cur  = (n_edges / D) % 4;
      dig  = snap_m[cur];
      dark = dif.blank || (dif.lzb_en && cur == 3 && dig == 0);
      exp_an = 4'hF;
      if (!dark) exp_an[cur] = 1'b0;
      exp_seg = dark ? 7'h7F : seg_lut[dig];
      exp_dp  = (cur == 2 && !dif.blank) ? 1'b0 : 1'b1;
      exp_ft  = ((n_edges + 1) % (4 * D)) == 0;
      if (exp_ft) begin
        snap_m[0] = int'(dif.sec_ones);
        snap_m[1] = int'(dif.sec_tens);
        snap_m[2] = int'(dif.min_ones);
        snap_m[3] = int'(dif.min_tens);
      end
      n_edges++;
    end
  endtask

  task automatic step(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("an",         32'(dif.an),         32'(exp_an));
      check("seg",        32'(dif.seg),        32'(exp_seg));
      check("dp",         32'(dif.dp),         32'(exp_dp));
      check("frame_tick", 32'(dif.frame_tick), 32'(exp_ft));
    end
  endtask

  task automatic set_digits(input logic [3:0] s1, input logic [3:0] s10,
                            input logic [3:0] m1, input logic [3:0] m10);
    dif.sec_ones = s1;
    dif.sec_tens = s10;
    dif.min_ones = m1;
    dif.min_tens = m10;
  endtask

  // Advance until the cycle right after a modelled snapshot, bounded to one frame
  task automatic step_past_snapshot();
    for (int k = 0; k < 4 * D + 1; k++) begin
      step(1);
      if (exp_ft) return;
    end
    check("snapshot_reached", 32'(exp_ft), 32'(1));
  endtask

  initial begin
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    dif.lzb_en = 1'b0;
    dif.blank  = 1'b0;

    // Reset held two cycles, then the empty first frame
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(6);

    // New digits mid-frame only appear after the 3->0 snapshot
    set_digits(4'd5, 4'd4, 4'd3, 4'd2);
    step(4 * D * 2);

    // Change shortly after a snapshot: current frame must stay intact
    step_past_snapshot();
    step(1);
    set_digits(4'd9, 4'd5, 4'd9, 4'd5);
    step(4 * D * 2);

    // Leading-zero blanking on/off
    set_digits(4'd1, 4'd2, 4'd3, 4'd0);
    dif.lzb_en = 1'b1;
    step(4 * D * 2);
    dif.lzb_en = 1'b0;
    step(4 * D);

    // Non-BCD value shows a dash
    set_digits(4'hC, 4'hA, 4'hF, 4'hB);
    step(4 * D * 2);

    // Blank mid-frame keeps scan phase, then reset mid-scan
    set_digits(4'd7, 4'd1, 4'd8, 4'd4);
    step(4 * D + 3);
    dif.blank = 1'b1;
    step(10);
    dif.blank = 1'b0;
    step(7);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(4 * D * 2);

    // Randomised traffic
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       dif.sec_ones = 4'($urandom_range(0, 15));
          1:       dif.sec_tens = 4'($urandom_range(0, 15));
          2:       dif.min_ones = 4'($urandom_range(0, 15));
          default: dif.min_tens = 4'($urandom_range(0, 3));
        endcase
      end
      if ($urandom_range(0, 19) == 0) dif.lzb_en = ~dif.lzb_en;
      if ($urandom_range(0, 24) == 0) dif.blank  = ~dif.blank;
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
